// File: rtl/ocram_dma_pkg.sv
// Shared types for the OCRAM block copier: FSM state encoding and byte-enable constant.
package ocram_dma_pkg;

   typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, FIN} state_e;

   localparam int unsigned MAX_BE_W = 64;
   localparam logic [MAX_BE_W-1:0] BE_ALL = {MAX_BE_W{1'b1}};

endpackage

// File: rtl/ocram_dma_fifo.sv
// Show-ahead staging FIFO between the read and write phases of the copier.
module ocram_dma_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wp_q, rp_q;
   logic [CW-1:0]     cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wp_q] <= din;
            wp_q        <= wp_q + AW'(1);
         end
         if (pop) rp_q <= rp_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign dout  = mem_q[rp_q];
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;

endmodule

// File: rtl/ocram_dma_copier.sv
// Avalon-MM master that copies a block of 64-bit words inside the on-chip RAM,
// reading a FIFO-sized batch, draining the read pipeline, then writing it back out.
module ocram_dma_copier
   import ocram_dma_pkg::*;
#(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 64,
   parameter int BE_W         = 8,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BE_W-1:0]   avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [RW-1:0]     rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
   logic [CW-1:0]     batch_q, batch_d, infl_q, infl_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [READ_LATENCY-1:0] vld_pipe_q;

   logic              rd_acc, wr_acc, push;
   logic              fifo_empty, fifo_full;
   logic [CW-1:0]     fifo_cnt;
   logic [DATA_W-1:0] fifo_dout;

   // Requests decode straight from the state register so an async reset drops them at once.
   assign avm_read       = (state_q == RD);
   assign avm_write      = (state_q == WR) && !fifo_empty;
   assign avm_chipselect = avm_read | avm_write;
   assign avm_address    = avm_read ? rd_ptr_q : (avm_write ? wr_ptr_q : '0);
   assign avm_writedata  = avm_write ? fifo_dout : '0;
   assign avm_byteenable = BE_ALL[BE_W-1:0];
   assign busy           = busy_q;
   assign done           = done_q;

   assign rd_acc = avm_read  & ~avm_waitrequest;
   assign wr_acc = avm_write & ~avm_waitrequest;
   assign push   = vld_pipe_q[READ_LATENCY-1] & ~fifo_full;

   always_comb begin
      infl_d = infl_q;
      if (rd_acc && !push)      infl_d = infl_q + CW'(1);
      else if (!rd_acc && push) infl_d = infl_q - CW'(1);
   end

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_rem_d = rd_rem_q;
      wr_rem_d = wr_rem_q;
      batch_d  = batch_q;
      busy_d   = busy_q;
      done_d   = (state_q == FIN);
      case (state_q)
         IDLE: if (start) begin
            rd_ptr_d = src_addr;
            wr_ptr_d = dst_addr;
            rd_rem_d = word_count;
            wr_rem_d = word_count;
            batch_d  = '0;
            busy_d   = 1'b1;
            state_d  = (word_count == '0) ? FIN : RD;
         end
         RD: if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            rd_rem_d = rd_rem_q - RW'(1);
            batch_d  = batch_q + CW'(1);
            if (batch_q == CW'(FIFO_DEPTH - 1) || rd_rem_q == RW'(1)) state_d = DRAIN;
         end
         DRAIN: if (infl_d == '0) state_d = WR;
         WR: if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            wr_rem_d = wr_rem_q - RW'(1);
            if (fifo_cnt == CW'(1)) begin
               batch_d = '0;
               state_d = (wr_rem_q == RW'(1)) ? FIN : RD;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_rem_q   <= '0;
         wr_rem_q   <= '0;
         batch_q    <= '0;
         infl_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_rem_q   <= rd_rem_d;
         wr_rem_q   <= wr_rem_d;
         batch_q    <= batch_d;
         infl_q     <= infl_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         vld_pipe_q <= (vld_pipe_q << 1) | READ_LATENCY'(rd_acc);
      end
   end

   ocram_dma_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (wr_acc),
      .din     (avm_readdata),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_cnt)
   );

endmodule

// File: tb/tb_ocram_dma_copier.sv
// Scoreboard bench for the OCRAM copier: instance 0 uses read latency 1, instance 1 latency 3 with random stalls.
module tb_ocram_dma_copier;

   localparam int AW = 13;
   localparam int DW = 64;
   localparam logic [DW-1:0] PAT = 64'hA5A5_0000_0000_0000;

   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          start [2];
   logic [AW-1:0] src [2], dst [2], addr [2];
   logic [AW:0]   cnt [2];
   logic          busy [2], done [2], cs [2], rd [2], wr [2], wt [2];
   logic [7:0]    be [2];
   logic [DW-1:0] wdata [2], rdata [2];
   logic          rnd_en = 1'b0, rnd_wt = 1'b0;

   wr_t           wq0 [$], wq1 [$];
   logic [AW-1:0] rq0 [$], rq1 [$];
   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_i
      localparam int RL = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [2**AW];
      bit            wrtn [2**AW];
      logic [DW-1:0] rsh [RL];
      int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, rw_viol = 0, stab_viol = 0;
      logic p_stall = 1'b0, p_rd, p_wr;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_wd;

      assign wt[g]    = (g == 1) ? rnd_wt : 1'b0;
      assign rdata[g] = rsh[RL-1];

      always @(posedge clk) begin
         if (wr[g] && !wt[g]) begin
            mem[addr[g]]  <= wdata[g];
            wrtn[addr[g]] <= 1'b1;
         end
         rsh[0] <= (rd[g] && !wt[g]) ? (wrtn[addr[g]] ? mem[addr[g]] : PAT + DW'(addr[g])) : '0;
         for (int i = 1; i < RL; i++) rsh[i] <= rsh[i-1];
      end

      always @(negedge clk) begin
         if (!reset_n) p_stall <= 1'b0;
         else begin
            if (rd[g] && wr[g]) rw_viol <= rw_viol + 1;
            if (p_stall && (addr[g] !== p_addr || rd[g] !== p_rd || wr[g] !== p_wr || wdata[g] !== p_wd))
               stab_viol <= stab_viol + 1;
            p_stall <= (rd[g] || wr[g]) && wt[g];
            p_addr  <= addr[g];
            p_rd    <= rd[g];
            p_wr    <= wr[g];
            p_wd    <= wdata[g];
            if (done[g]) done_cnt <= done_cnt + 1;
            if (rd[g] && !wt[g]) begin
               rd_cnt <= rd_cnt + 1;
               if (g == 0) begin
                  chk("rd_pending", rq0.size() != 0, 1);
                  if (rq0.size() != 0) begin chk("rd_addr", addr[g], rq0[0]); void'(rq0.pop_front()); end
               end else begin
                  chk("rd_pending", rq1.size() != 0, 1);
                  if (rq1.size() != 0) begin chk("rd_addr", addr[g], rq1[0]); void'(rq1.pop_front()); end
               end
            end
            if (wr[g] && !wt[g]) begin
               wr_cnt <= wr_cnt + 1;
               if (g == 0) begin
                  chk("wr_pending", wq0.size() != 0, 1);
                  if (wq0.size() != 0) begin
                     chk("wr_addr", addr[g], wq0[0].a);
                     chk("wr_data", wdata[g], wq0[0].d);
                     void'(wq0.pop_front());
                  end
               end else begin
                  chk("wr_pending", wq1.size() != 0, 1);
                  if (wq1.size() != 0) begin
                     chk("wr_addr", addr[g], wq1[0].a);
                     chk("wr_data", wdata[g], wq1[0].d);
                     void'(wq1.pop_front());
                  end
               end
            end
         end
      end

      ocram_dma_copier #(.ADDR_W(AW), .DATA_W(DW), .BE_W(8), .READ_LATENCY(RL), .FIFO_DEPTH(4)) u_dut (
         .clk             (clk),
         .reset_n         (reset_n),
         .start           (start[g]),
         .src_addr        (src[g]),
         .dst_addr        (dst[g]),
         .word_count      (cnt[g]),
         .busy            (busy[g]),
         .done            (done[g]),
         .avm_address     (addr[g]),
         .avm_byteenable  (be[g]),
         .avm_chipselect  (cs[g]),
         .avm_read        (rd[g]),
         .avm_write       (wr[g]),
         .avm_writedata   (wdata[g]),
         .avm_readdata    (rdata[g]),
         .avm_waitrequest (wt[g])
      );
   end

   function automatic int dcnt(input int k);
      return (k == 0) ? g_i[0].done_cnt : g_i[1].done_cnt;
   endfunction
   function automatic int wcnt(input int k);
      return (k == 0) ? g_i[0].wr_cnt : g_i[1].wr_cnt;
   endfunction
   function automatic int rcnt(input int k);
      return (k == 0) ? g_i[0].rd_cnt : g_i[1].rd_cnt;
   endfunction
   function automatic int qsz(input int k);
      return (k == 0) ? wq0.size() + rq0.size() : wq1.size() + rq1.size();
   endfunction

   task automatic push_exp(input int k, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] sa, da;
         sa = s + AW'(i);
         da = d + AW'(i);
         if (k == 0) begin rq0.push_back(sa); wq0.push_back('{a: da, d: PAT + DW'(sa)}); end
         else        begin rq1.push_back(sa); wq1.push_back('{a: da, d: PAT + DW'(sa)}); end
      end
   endtask

   task automatic pulse(input int k, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
      @(posedge clk); #1;
      start[k] = 1'b1; src[k] = s; dst[k] = d; cnt[k] = (AW+1)'(n);
      @(posedge clk); #1;
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int d0);
      bit seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         if (dcnt(k) != d0) begin seen = 1'b1; break; end
      end
      chk("done_seen", seen, 1);
   endtask

   task automatic copy(input int k, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input bit intf);
      int d0, w0;
      d0 = dcnt(k);
      w0 = wcnt(k);
      push_exp(k, s, d, n);
      pulse(k, s, d, n);
      @(negedge clk);
      chk("busy_set", busy[k], 1);
      if (intf) begin
         repeat (4) @(posedge clk);
         #1; start[k] = 1'b1; src[k] = 13'h600; dst[k] = 13'h700; cnt[k] = 14'd3;
         @(posedge clk); #1; start[k] = 1'b0;
      end
      wait_done(k, d0);
      repeat (3) @(posedge clk);
      #2;
      chk("done_once", dcnt(k) - d0, 1);
      chk("busy_clr", busy[k], 0);
      chk("sb_empty", qsz(k), 0);
      chk("wr_count", wcnt(k) - w0, n);
   endtask

   initial forever begin
      @(posedge clk); #1;
      rnd_wt = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, r0, w0;
      bit seen;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; src[k] = '0; dst[k] = '0; cnt[k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", busy[0], 0);
      chk("rst_done", done[0], 0);
      chk("rst_read", rd[0], 0);
      chk("rst_write", wr[0], 0);
      chk("rst_cs", cs[0], 0);
      chk("rst_addr", addr[0], 0);
      chk("rst_wdata", wdata[0], 0);
      chk("byteenable", be[0], 8'hFF);
      @(posedge clk); #1 reset_n = 1'b1;

      // basic copy, then destination contents in the slave model
      copy(0, 13'h010, 13'h100, 8, 1'b0);
      for (int i = 0; i < 8; i++) chk("t1_mem", g_i[0].mem[13'h100 + AW'(i)], PAT + DW'(16 + i));

      // zero-length copy: no bus traffic, done two cycles after start
      d0 = dcnt(0); r0 = rcnt(0); w0 = wcnt(0);
      pulse(0, 13'h055, 13'h066, 0);
      @(negedge clk); chk("zero_done_t1", done[0], 0);
      @(negedge clk); chk("zero_done_t2", done[0], 1);
      @(negedge clk); chk("zero_done_t3", done[0], 0);
      repeat (3) @(posedge clk); #2;
      chk("zero_rd", rcnt(0) - r0, 0);
      chk("zero_wr", wcnt(0) - w0, 0);
      chk("zero_done_once", dcnt(0) - d0, 1);

      // address wrap on the source side
      copy(0, 13'h1FFE, 13'h0800, 4, 1'b0);

      // latency 3 with random stalls
      rnd_en = 1'b1;
      copy(1, 13'h040, 13'h400, 13, 1'b0);
      rnd_en = 1'b0;

      // start while busy is ignored
      copy(0, 13'h200, 13'h300, 8, 1'b1);

      // reset during the write phase
      d0 = dcnt(0);
      push_exp(0, 13'h020, 13'h120, 8);
      pulse(0, 13'h020, 13'h120, 8);
      seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (wr[0]) begin seen = 1'b1; break; end
      end
      chk("t6_wr_seen", seen, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_read", rd[0], 0);
      chk("arst_write", wr[0], 0);
      chk("arst_cs", cs[0], 0);
      chk("arst_busy", busy[0], 0);
      wq0.delete();
      rq0.delete();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #2 chk("arst_no_done", dcnt(0) - d0, 0);
      copy(0, 13'h030, 13'h130, 5, 1'b0);

      chk("rw_excl0", g_i[0].rw_viol, 0);
      chk("rw_excl1", g_i[1].rw_viol, 0);
      chk("stall_stable1", g_i[1].stab_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
